// File: rtl/bridge_timer.sv
// bridge_timer: memory-mapped down-counting timer on the device side of the
// CPU-to-peripheral bridge. Zero-latency register reads, byte-enabled writes,
// one-shot / auto-reload counting and a registered interrupt line.
module bridge_timer #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic               r_irq;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   r_count;

    logic               w_ctrl_wr;
    logic               w_ctrl_wr_b0;
    logic               w_preset_wr;
    logic               w_enter_int;
    logic               w_hw_en_clr;
    logic               w_pulse_clr;
    logic               w_auto_reload;
    logic [31:0]        w_preset_ext;
    logic [31:0]        w_count_ext;
    logic [31:0]        w_preset_merge;

    assign w_ctrl_wr     = we && (addr == 2'd0);
    assign w_ctrl_wr_b0  = w_ctrl_wr && be[0];
    assign w_preset_wr   = we && (addr == 2'd1);
    assign w_auto_reload = (r_mode == 2'd1) || (r_mode == 2'd2);
    assign w_enter_int   = (r_state == S_CNT) && (w_next_state == S_INT);
    // One-shot (modes 0/3) drops EN when leaving INT; mode 1 makes irq a pulse.
    assign w_hw_en_clr   = (r_state == S_INT) && !w_auto_reload;
    assign w_pulse_clr   = (r_state == S_INT) && (r_mode == 2'd1);
    assign irq           = r_irq;

    // Zero-extend the CNT_W-wide registers to the 32-bit bus view and merge
    // a byte-enabled write into the current PRESET value.
    always_comb begin
        w_preset_ext              = '0;
        w_count_ext               = '0;
        w_preset_ext[CNT_W-1:0]   = r_preset;
        w_count_ext[CNT_W-1:0]    = r_count;
        w_preset_merge            = w_preset_ext;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                w_preset_merge[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Combinational read mux; reads have no side effects.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = {27'd0, r_irq, r_im, r_mode, r_en};
            2'd1:    rdata = w_preset_ext;
            2'd2:    rdata = w_count_ext;
            default: rdata = '0;
        endcase
    end

    // Next-state logic of the counting FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = r_en ? S_LOAD : S_IDLE;
            S_LOAD: w_next_state = r_en ? S_CNT : S_IDLE;
            S_CNT: begin
                if (!r_en) begin
                    w_next_state = S_IDLE;
                end else if (r_count <= CNT_W'(1)) begin
                    w_next_state = S_INT;
                end
            end
            S_INT: begin
                if (!r_en) begin
                    w_next_state = S_IDLE;
                end else if (w_auto_reload) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // CTRL fields: a CPU write of byte 0 wins over the hardware EN clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en   <= 1'b0;
            r_mode <= 2'd0;
            r_im   <= 1'b0;
        end else if (w_ctrl_wr_b0) begin
            r_en   <= wdata[0];
            r_mode <= wdata[2:1];
            r_im   <= wdata[3];
        end else if (w_hw_en_clr) begin
            r_en   <= 1'b0;
        end
    end

    // PRESET register, byte-enabled writes truncated to CNT_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_preset <= '0;
        end else if (w_preset_wr) begin
            r_preset <= w_preset_merge[CNT_W-1:0];
        end
    end

    // COUNT: reload in LOAD, count down in CNT, saturating at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_state == S_LOAD) begin
            r_count <= r_preset;
        end else if ((r_state == S_CNT) && r_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Interrupt: setting on INT entry beats a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if (w_enter_int && r_im) begin
            r_irq <= 1'b1;
        end else if (w_ctrl_wr || w_pulse_clr) begin
            r_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bridge_timer.sv
// Testbench for bridge_timer: per-scenario tasks; expected COUNT/irq values
// per cycle are queued when stimulus is applied and popped as cycles elapse.
module tb_bridge_timer;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        logic [31:0] cnt;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    bridge_timer #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr  = a;
        wdata = d;
        be    = b;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic sb_push(input logic [31:0] c, input logic q);
        exp_t e;
        e.cnt = c;
        e.irq = q;
        sb_q.push_back(e);
    endtask

    // Advance one cycle, pop the expectation for it and sample COUNT and irq.
    task automatic sb_next(output exp_t e, output logic [31:0] c, output logic q);
        e = sb_q.pop_front();
        step();
        rd(2'd2, c);
        q = irq;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        we = 1'b0; addr = 2'd0; be = 4'h0; wdata = '0;
        repeat (3) step();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_rdata addr%0d: got %h, want 00000000", a, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, want 0", irq);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_one_shot();
        exp_t e;
        logic [31:0] c, v;
        logic q;
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        step();
        for (int i = 0; i < 6; i++) sb_push(32'(5 - i), (i == 5));
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL one_shot_count: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        step();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h18) begin
            errors++;
            $display("FAIL one_shot_ctrl: got %h, want 00000018", v);
        end
        for (int i = 0; i < 19; i++) sb_push(32'd0, 1'b1);
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL one_shot_sticky: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        wr(2'd0, 32'h0, 4'hF);
        rd(2'd0, v);
        checks++;
        if (irq !== 1'b0 || v !== 32'h0) begin
            errors++;
            $display("FAIL one_shot_clear: got irq=%b ctrl=%h, want irq=0 ctrl=00000000", irq, v);
        end
    endtask

    task automatic test_auto_reload_pulse();
        exp_t e;
        logic [31:0] c;
        logic q;
        logic [31:0] pat [5];
        pat[0] = 32'd3; pat[1] = 32'd2; pat[2] = 32'd1; pat[3] = 32'd0; pat[4] = 32'd0;
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        step();
        for (int j = 0; j < 15; j++) sb_push(pat[j % 5], ((j % 5) == 3));
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL auto_reload_pulse: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        wr(2'd0, 32'h0, 4'hF);
        step();
    endtask

    task automatic test_mask_be();
        exp_t e;
        logic [31:0] c, v;
        logic q;
        wr(2'd1, 32'h0, 4'hF);
        wr(2'd1, 32'hAABBCCDD, 4'b0101);
        rd(2'd1, v);
        checks++;
        if (v !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL preset_byte_enable: got %h, want 00BB00DD", v);
        end
        wr(2'd1, 32'd4, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        step();
        for (int i = 0; i < 11; i++) sb_push((i < 4) ? 32'(4 - i) : 32'd0, 1'b0);
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL masked_count: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL masked_ctrl_idle: got %h, want 00000000", v);
        end
    endtask

    task automatic test_preset_zero();
        exp_t e;
        logic [31:0] c;
        logic q;
        wr(2'd1, 32'h0, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b1);
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL preset_zero: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        wr(2'd0, 32'h0, 4'hF);
        step();
    endtask

    task automatic test_en_stop();
        exp_t e;
        logic [31:0] c, v;
        logic q;
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        repeat (4) step();
        wr(2'd0, 32'h8, 4'hF);
        for (int i = 0; i < 6; i++) sb_push(32'd2, 1'b0);
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL en_stop_hold: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL en_stop_ctrl: got %h, want 00000008", v);
        end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] v;
        wr(2'd2, 32'h55, 4'hF);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL count_write_ignored: got %h, want 00000002", v);
        end
        wr(2'd3, 32'hFFFFFFFF, 4'hF);
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL addr3_read: got %h, want 00000000", v);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL preset_unaffected: got %h, want 00000005", v);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic [31:0] c, v;
        logic q;
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        repeat (3) step();
        wr(2'd0, 32'h9, 4'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: got irq=%b, want 1", irq);
        end
        wr(2'd0, 32'h9, 4'hF);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h9 || irq !== 1'b0) begin
            errors++;
            $display("FAIL cpu_beats_hw_clear: got ctrl=%h irq=%b, want ctrl=00000009 irq=0", v, irq);
        end
        sb_push(32'd0, 1'b0);
        sb_push(32'd2, 1'b0);
        while (sb_q.size() > 0) begin
            sb_next(e, c, q);
            checks++;
            if (c !== e.cnt || q !== e.irq) begin
                errors++;
                $display("FAIL restart_after_race: got cnt=%0d irq=%b, want cnt=%0d irq=%b", c, q, e.cnt, e.irq);
            end
        end
        wr(2'd0, 32'h0, 4'hF);
        step();
    endtask

    task automatic test_reset_midcount();
        logic [31:0] c, v;
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        repeat (4) step();
        rd(2'd2, c);
        checks++;
        if (c !== 32'd3) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, want 3", c);
        end
        #2;
        rst = 1'b0;
        #1;
        rd(2'd2, c);
        rd(2'd0, v);
        checks++;
        if (c !== 32'd0 || v !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d ctrl=%h irq=%b, want 0 00000000 0", c, v, irq);
        end
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_one_shot();
        test_auto_reload_pulse();
        test_mask_be();
        test_preset_zero();
        test_en_stop();
        test_ignored_writes();
        test_simultaneous();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_timer.md
Name: bridge_timer

Overview:
- Memory-mapped down-counting timer that sits on the device side of the CPU-to-peripheral bridge.
- It answers bridge register reads and writes (word address, byte enables, write strobe) and drives one hardware interrupt line toward the CPU HWInt bus.
- It is the responder end of the Pr* bus that the CPU initiates.
- It provides one-shot and auto-reload modes and a sticky or pulsed interrupt.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (1..32). Reads zero-extend to 32 bits; writes truncate to CNT_W bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- addr  input  2  word address inside the block: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  input  1  write strobe from the bridge, one cycle per write
- be  input  4  byte enables for writes; be[i] gates wdata[8i+7:8i]
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr (zero-latency read)
- irq  output  1  interrupt request to the bridge HWInt input; registered

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-count):
  - CTRL=0, PRESET=0, COUNT=0, FSM=IDLE, irq=0.
  - rdata follows addr with the reset register values.
- CTRL bit fields:
  - [0] EN.
  - [2:1] MODE: 0 one-shot; 1 auto-reload with 1-cycle irq pulse; 2 auto-reload with sticky irq; 3 behaves as 0.
  - [3] IM (interrupt mask, 1=enabled).
  - [4] PEND, read-only and equal to irq.
  - [31:5] read as 0.
- Writes (we=1):
  - CTRL and PRESET are updated per byte enable on the same edge.
  - Writes to COUNT and to addr 3 are ignored.
  - Any write to CTRL clears irq on that edge.
- Reads:
  - rdata = CTRL / PRESET / COUNT for addr 0/1/2, and 0 for addr 3.
  - Reads have no side effects.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD on the next edge; otherwise stay. COUNT holds its value.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and COUNT holds.
    - Else if COUNT>1, COUNT <= COUNT-1.
    - Else if COUNT==1, COUNT <= 0 and go to INT.
    - Else (COUNT==0, i.e. PRESET=0), go to INT.
  - INT:
    - Entering INT sets irq <= IM on that same edge.
    - MODE 0/3: hardware clears EN on the next edge, goes to IDLE, and irq stays set until a CTRL write.
    - MODE 1: go to LOAD; irq is cleared on the next edge (1-cycle pulse).
    - MODE 2: go to LOAD; irq stays set until a CTRL write.
- Timing:
  - Write EN=1 at edge k → LOAD at k+1 → COUNT=PRESET at k+2 → irq rises at edge k+2+max(PRESET,1).
  - Auto-reload period = max(PRESET,1)+2 cycles.
- Simultaneous events:
  - A CPU CTRL write on the same edge as the hardware EN clear in INT: the CPU value wins.
  - A CPU CTRL write on the same edge irq would be set: irq is set (the set wins over the clear).
  - A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
  - EN=0 written during LOAD or INT: the FSM goes to IDLE next edge. irq keeps its value unless cleared by that CTRL write.
- Width rule: COUNT never underflows; it saturates at 0.

Test Plan:
- Reset: assert rst=0 mid-count with COUNT=3 → COUNT=0, irq=0, rdata at addr 0 = 0 immediately, without waiting for a clock edge.
- One-shot: PRESET=5, then write CTRL=0x9 (EN, MODE0, IM) at edge k → COUNT reads 5,4,3,2,1,0 at k+2..k+7, irq=1 from k+7, CTRL reads 0x18 from k+8. irq stays high 20 cycles, then a CTRL=0 write clears it.
- Auto-reload pulse: PRESET=3, CTRL=0xB → irq is a 1-cycle high pulse every 5 cycles, repeated at least 3 times. COUNT sequence 3,2,1,0,(INT),(LOAD),3...
- Mask and byte enables: PRESET write 0xAABBCCDD with be=0b0101 over a PRESET of 0 → PRESET=0x00BB00DD. Then CTRL=0x1 (IM=0), count expires → irq stays 0 and the FSM returns to IDLE.
- Edge cases:
  - PRESET=0 with EN=1, MODE0 → irq rises 3 edges after the write.
  - Write EN=0 at COUNT=2 → COUNT holds 2 and the FSM is IDLE.
  - A COUNT write of 0x55 is ignored.
  - Reading addr 3 returns 0.
